// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver.
//   P_EVEN / P_ODD / P_NONE : parity configuration encodings (bit 1 set = no parity)
//   rx_state_t              : receiver FSM states
//   calc_div                : system clocks per oversample tick
package uart_pkg;

    localparam logic [1:0] P_EVEN = 2'b00;
    localparam logic [1:0] P_ODD  = 2'b01;
    localparam logic [1:0] P_NONE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2,
        BREAK
    } rx_state_t;

    function automatic int calc_div(input int sys_freq, input int baud, input int os_rate);
        return sys_freq / (baud * os_rate);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO holding received frames.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (contents discarded)
//   i_push     : write request; accepted when not full, or when full with a pop
//   i_wdata    : word to write
//   i_pop      : read request; ignored when empty
//   o_rdata    : head word, zero when empty
//   o_full     : all DEPTH entries occupied
//   o_empty    : no entries
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    // Wrap bit differs with equal index bits: writer is one lap ahead.
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver, OS_RATE-times oversampled with a 2-of-3 majority vote per bit.
// Frames are pushed into a FWFT FIFO as {ferr, perr, data}; a break frame
// (all zero through the first stop bit) pulses break_det and is not pushed.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rxd                 : serial line, idle high, LSB first
//   parity, stop_bits   : frame format, latched at the start edge
//   rx_data/perr/ferr   : FIFO head word, valid while rx_valid
//   rx_valid, rx_ready  : head handshake, pop on rx_valid & rx_ready
//   overrun             : pulse, finished frame dropped on a full FIFO
//   break_det           : pulse, break condition seen
//   busy                : receiver outside IDLE
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synced line
// START  | checking the start bit; a high vote is treated as a glitch
// DATA   | shifting in DATA_W bits, LSB first
// PARITY | checking the parity bit
// STOP   | first stop bit; frame end, break detection, or on to STOP2
// STOP2  | second stop bit; frame end
// BREAK  | line held low; wait for it to return high
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int SYS_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OS_RATE    = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    input  logic [1:0]        parity,
    input  logic              stop_bits,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_perr,
    output logic              rx_ferr,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              break_det,
    output logic              busy
);

    localparam int DIV   = calc_div(SYS_FREQ, BAUD, OS_RATE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OS_RATE);
    localparam int BC_W  = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [OS_W-1:0]  OS_S0    = OS_W'(OS_RATE/2 - 1);
    localparam logic [OS_W-1:0]  OS_S1    = OS_W'(OS_RATE/2);
    localparam logic [OS_W-1:0]  OS_S2    = OS_W'(OS_RATE/2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS_RATE - 1);
    localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
    localparam logic [BC_W-1:0]  BC_FULL  = BC_W'(DATA_W);
    localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);

    logic              r_sync1, r_sync2, r_sync3;
    rx_state_t         r_state;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [OS_W-1:0]   r_os;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_s0, r_s1;
    logic [1:0]        r_par_cfg;
    logic              r_stop2;
    logic              r_perr;
    logic              r_par_bit;
    logic              r_ferr1;
    logic              r_overrun;
    logic              r_break;

    logic              w_line;
    logic              w_fall;
    logic              w_tick;
    logic              w_dec;
    logic              w_end;
    logic              w_vote;
    logic              w_par_en;
    logic              w_is_break;
    logic              w_push;
    logic              w_push_ferr;
    logic [DATA_W+1:0] w_push_data;
    logic [DATA_W+1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_line   = r_sync2;
    assign w_fall   = r_sync3 & ~r_sync2;
    assign w_tick   = (r_state != IDLE) && (r_div_cnt == '0);
    // Third sample is the live line at the decision tick.
    assign w_dec    = w_tick && (r_os == OS_S2);
    assign w_end    = w_tick && (r_os == OS_LAST);
    assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_line) | (r_s1 & w_line);
    assign w_par_en = ~r_par_cfg[1];

    assign w_is_break = (r_state == STOP) && !w_vote && (r_shift == '0) &&
                        (!w_par_en || !r_par_bit);

    assign w_push      = w_dec && (((r_state == STOP) && !w_is_break && !r_stop2) ||
                                   (r_state == STOP2));
    assign w_push_ferr = (r_state == STOP2) ? (r_ferr1 | ~w_vote) : ~w_vote;
    assign w_push_data = {w_push_ferr, r_perr, r_shift};
    assign w_pop       = ~w_empty & rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_div_cnt <= DIV_LOAD;
            r_os      <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_par_cfg <= P_NONE;
            r_stop2   <= 1'b0;
            r_perr    <= 1'b0;
            r_par_bit <= 1'b0;
            r_ferr1   <= 1'b0;
            r_overrun <= 1'b0;
            r_break   <= 1'b0;
        end else begin
            r_overrun <= w_push & w_full & ~w_pop;
            r_break   <= 1'b0;

            // Held loaded in IDLE so the first tick lands DIV clocks after the start edge.
            if (r_state == IDLE || w_tick) begin
                r_div_cnt <= DIV_LOAD;
            end else begin
                r_div_cnt <= r_div_cnt - DIV_ONE;
            end

            if (r_state == IDLE) begin
                r_os <= '0;
            end else if (w_tick) begin
                r_os <= (r_os == OS_LAST) ? '0 : r_os + OS_ONE;
            end

            if (w_tick && r_os == OS_S0) r_s0 <= w_line;
            if (w_tick && r_os == OS_S1) r_s1 <= w_line;

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state   <= START;
                        r_par_cfg <= parity;
                        r_stop2   <= stop_bits;
                        r_bit_cnt <= '0;
                        r_perr    <= 1'b0;
                        r_par_bit <= 1'b0;
                        r_ferr1   <= 1'b0;
                    end
                end
                START: begin
                    if (w_dec && w_vote) begin
                        r_state <= IDLE;
                    end else if (w_end) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_dec) begin
                        r_shift   <= {w_vote, r_shift[DATA_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + BC_ONE;
                    end
                    if (w_end && r_bit_cnt == BC_FULL) begin
                        r_state <= w_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (w_dec) begin
                        r_par_bit <= w_vote;
                        r_perr    <= ((^r_shift) ^ w_vote) != (r_par_cfg == P_ODD);
                    end
                    if (w_end) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_dec) begin
                        if (w_is_break) begin
                            r_state <= BREAK;
                            r_break <= 1'b1;
                        end else if (r_stop2) begin
                            r_ferr1 <= ~w_vote;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_end) begin
                        r_state <= STOP2;
                    end
                end
                STOP2: begin
                    if (w_dec) begin
                        r_state <= IDLE;
                    end
                end
                BREAK: begin
                    if (w_line) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rx_data   = w_head[DATA_W-1:0];
    assign rx_perr   = w_head[DATA_W];
    assign rx_ferr   = w_head[DATA_W+1];
    assign rx_valid  = ~w_empty;
    assign overrun   = r_overrun;
    assign break_det = r_break;
    assign busy      = (r_state != IDLE);

endmodule
